// File: rtl/ex_operand_stage_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes, forwarding select codes.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [RIDX_W-1:0] ridx_t;

  // ALU op codes
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  // Operand source selects produced by the forwarding unit
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // ID/EX pipeline register contents
  typedef struct packed {
    logic       valid;
    ridx_t      rs1;
    ridx_t      rs2;
    ridx_t      rd;
    word_t      rs1_data;
    word_t      rs2_data;
    word_t      imm;
    word_t      pc;
    logic       src1_pc;
    logic       src2_imm;
    logic [3:0] aluctrl;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
  } ex_regs_t;

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_select(ridx_t rs, ridx_t exmem_rd, logic exmem_we,
                                            ridx_t memwb_rd, logic memwb_we);
    logic [1:0] sel;
    sel = FWD_REG;
    if (rs != '0) begin
      if (exmem_we && (exmem_rd == rs))      sel = FWD_EXMEM;
      else if (memwb_we && (memwb_rd == rs)) sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID-to-EX bus: decoded fields, flush/stall, forwarding sources and ALU-facing outputs.
// Latency: wires only.
// Backpressure: stall_id flows back to ID; stall_ext freezes the stage.
interface ex_operand_stage_if;
  import cpu_pkg::*;

  logic       id_valid;
  ridx_t      id_rs1;
  ridx_t      id_rs2;
  ridx_t      id_rd;
  word_t      id_rs1_data;
  word_t      id_rs2_data;
  word_t      id_imm;
  word_t      id_pc;
  logic       id_src1_pc;
  logic       id_src2_imm;
  logic [3:0] id_aluctrl;
  logic       id_memread;
  logic       id_memwrite;
  logic       id_regwrite;
  logic       flush;
  logic       stall_ext;
  ridx_t      exmem_rd;
  logic       exmem_regwrite;
  word_t      exmem_result;
  ridx_t      memwb_rd;
  logic       memwb_regwrite;
  word_t      memwb_wdata;

  word_t      alu_src1;
  word_t      alu_src2;
  logic [3:0] alu_aluctrl;
  logic       ex_valid;
  ridx_t      ex_rd;
  logic       ex_regwrite;
  logic       ex_memread;
  logic       ex_memwrite;
  word_t      ex_store_data;
  logic       stall_id;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_src1_pc, id_src2_imm, id_aluctrl, id_memread, id_memwrite, id_regwrite,
           flush, stall_ext, exmem_rd, exmem_regwrite, exmem_result,
           memwb_rd, memwb_regwrite, memwb_wdata,
    input  alu_src1, alu_src2, alu_aluctrl, ex_valid, ex_rd, ex_regwrite,
           ex_memread, ex_memwrite, ex_store_data, stall_id
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_src1_pc, id_src2_imm, id_aluctrl, id_memread, id_memwrite, id_regwrite,
           flush, stall_ext, exmem_rd, exmem_regwrite, exmem_result,
           memwb_rd, memwb_regwrite, memwb_wdata,
    output alu_src1, alu_src2, alu_aluctrl, ex_valid, ex_rd, ex_regwrite,
           ex_memread, ex_memwrite, ex_store_data, stall_id
  );

endinterface

// File: rtl/ex_operand_stage_fwd_unit.sv
// Forwarding unit: picks register, EX/MEM or MEM/WB as the source of each EX operand.
// Latency: purely combinational.
// Backpressure: none.
module fwd_unit
  import cpu_pkg::*;
(
  input  ridx_t      rs1_i,
  input  ridx_t      rs2_i,
  input  ridx_t      exmem_rd_i,
  input  logic       exmem_regwrite_i,
  input  ridx_t      memwb_rd_i,
  input  logic       memwb_regwrite_i,
  output logic [1:0] sel1_o,
  output logic [1:0] sel2_o
);

  // Resolve both sources against the two in-flight producers
  always_comb begin
    sel1_o = fwd_select(rs1_i, exmem_rd_i, exmem_regwrite_i, memwb_rd_i, memwb_regwrite_i);
    sel2_o = fwd_select(rs2_i, exmem_rd_i, exmem_regwrite_i, memwb_rd_i, memwb_regwrite_i);
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register plus operand select: forwarding, PC/imm muxing, load-use stall generation.
// Latency: ID fields land in EX 1 cycle after capture; operand muxing is combinational.
// Backpressure: stall_ext freezes EX; a load-use hazard raises stall_id and inserts a bubble.
module ex_operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ex_operand_stage_if.slave ex_if
);

  ex_regs_t   ex_q, ex_d;
  logic       flush_pend_q, flush_pend_d;
  logic [1:0] sel1, sel2;
  word_t      fwd_rs1, fwd_rs2;
  logic       haz;

  // One forwarding unit; its rs2 select feeds both the ALU operand and the store data
  fwd_unit u_fwd (
    .rs1_i            (ex_q.rs1),
    .rs2_i            (ex_q.rs2),
    .exmem_rd_i       (ex_if.exmem_rd),
    .exmem_regwrite_i (ex_if.exmem_regwrite),
    .memwb_rd_i       (ex_if.memwb_rd),
    .memwb_regwrite_i (ex_if.memwb_regwrite),
    .sel1_o           (sel1),
    .sel2_o           (sel2)
  );

  function automatic word_t resolve(logic [1:0] sel, ridx_t rs, word_t regdata,
                                    word_t exres, word_t wbdata);
    word_t r;
    case (sel)
      FWD_EXMEM: r = exres;
      FWD_MEMWB: r = wbdata;
      default:   r = (rs == '0) ? '0 : regdata;
    endcase
    return r;
  endfunction

  // Forwarded source values from the EX registers and the bypass buses
  always_comb begin
    fwd_rs1 = resolve(sel1, ex_q.rs1, ex_q.rs1_data, ex_if.exmem_result, ex_if.memwb_wdata);
    fwd_rs2 = resolve(sel2, ex_q.rs2, ex_q.rs2_data, ex_if.exmem_result, ex_if.memwb_wdata);
  end

  // A load in EX whose rd is read by the ID instruction; immediate-form consumers stall too
  assign haz = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && ex_if.id_valid &&
               ((ex_q.rd == ex_if.id_rs1) || (ex_q.rd == ex_if.id_rs2));

  assign ex_if.stall_id      = haz && !ex_if.stall_ext;
  assign ex_if.alu_src1      = ex_q.src1_pc  ? ex_q.pc  : fwd_rs1;
  assign ex_if.alu_src2      = ex_q.src2_imm ? ex_q.imm : fwd_rs2;
  assign ex_if.ex_store_data = fwd_rs2;
  assign ex_if.alu_aluctrl   = ex_q.aluctrl;
  assign ex_if.ex_valid      = ex_q.valid;
  assign ex_if.ex_rd         = ex_q.rd;
  assign ex_if.ex_regwrite   = ex_q.regwrite;
  assign ex_if.ex_memread    = ex_q.memread;
  assign ex_if.ex_memwrite   = ex_q.memwrite;

  // Next EX contents: hold on external stall, otherwise flush > hazard bubble > capture
  always_comb begin
    ex_d         = ex_q;
    flush_pend_d = flush_pend_q;
    if (ex_if.stall_ext) begin
      // a flush arriving during a freeze must still kill the next capture
      if (ex_if.flush) flush_pend_d = 1'b1;
    end else if (ex_if.flush || flush_pend_q) begin
      ex_d         = '0;
      flush_pend_d = 1'b0;
    end else if (haz) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = ex_if.id_valid;
      ex_d.rs1      = ex_if.id_rs1;
      ex_d.rs2      = ex_if.id_rs2;
      ex_d.rd       = ex_if.id_rd;
      ex_d.rs1_data = ex_if.id_rs1_data;
      ex_d.rs2_data = ex_if.id_rs2_data;
      ex_d.imm      = ex_if.id_imm;
      ex_d.pc       = ex_if.id_pc;
      ex_d.src1_pc  = ex_if.id_src1_pc;
      ex_d.src2_imm = ex_if.id_src2_imm;
      ex_d.aluctrl  = ex_if.id_aluctrl;
      ex_d.memread  = ex_if.id_memread;
      ex_d.memwrite = ex_if.id_memwrite;
      ex_d.regwrite = ex_if.id_regwrite;
    end
  end

  // EX register state; reset clears everything including a pending flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized bench for ex_operand_stage against an instruction-level model, plus directed cases.
// Latency: model advances one instruction slot per clock edge.
// Backpressure: random stall_ext/flush and load-use sequences exercise stall_id.
module tb_ex_operand_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_operand_stage_if bus ();
  ex_operand_stage dut (.clk(clk), .rst_n(rst_n), .ex_if(bus));

  int n_vec = 0;
  int n_err = 0;

  // One instruction as seen by the execute stage
  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic        s1pc, s2imm;
    logic [3:0]  ctrl;
    logic        mr, mw, rw;
  } ins_t;

  ins_t m_ex;
  bit   m_pend;

  logic [3:0] ops [9];

  function automatic ins_t bubble();
    ins_t b;
    b.v = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.d1 = 0; b.d2 = 0; b.imm = 0; b.pc = 0;
    b.s1pc = 0; b.s2imm = 0; b.ctrl = 0; b.mr = 0; b.mw = 0; b.rw = 0;
    return b;
  endfunction

  function automatic ins_t id_ins();
    ins_t i;
    i.v = bus.id_valid; i.rs1 = bus.id_rs1; i.rs2 = bus.id_rs2; i.rd = bus.id_rd;
    i.d1 = bus.id_rs1_data; i.d2 = bus.id_rs2_data; i.imm = bus.id_imm; i.pc = bus.id_pc;
    i.s1pc = bus.id_src1_pc; i.s2imm = bus.id_src2_imm; i.ctrl = bus.id_aluctrl;
    i.mr = bus.id_memread; i.mw = bus.id_memwrite; i.rw = bus.id_regwrite;
    return i;
  endfunction

  // Value of register idx as seen by the instruction in EX
  function automatic logic [31:0] opnd(logic [4:0] idx, logic [31:0] regv);
    if (idx == 0) return 32'h0;
    if (bus.exmem_regwrite && bus.exmem_rd == idx) return bus.exmem_result;
    if (bus.memwb_regwrite && bus.memwb_rd == idx) return bus.memwb_wdata;
    return regv;
  endfunction

  function automatic bit load_use();
    return m_ex.v && m_ex.mr && (m_ex.rd != 0) && bus.id_valid &&
           ((m_ex.rd == bus.id_rs1) || (m_ex.rd == bus.id_rs2));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("alu_src1", bus.alu_src1, m_ex.s1pc ? m_ex.pc : opnd(m_ex.rs1, m_ex.d1));
    chk("alu_src2", bus.alu_src2, m_ex.s2imm ? m_ex.imm : opnd(m_ex.rs2, m_ex.d2));
    chk("store_data", bus.ex_store_data, opnd(m_ex.rs2, m_ex.d2));
    chk("aluctrl", 32'(bus.alu_aluctrl), 32'(m_ex.ctrl));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_ex.v));
    chk("ex_rd", 32'(bus.ex_rd), 32'(m_ex.rd));
    chk("ex_regwrite", 32'(bus.ex_regwrite), 32'(m_ex.rw));
    chk("ex_memread", 32'(bus.ex_memread), 32'(m_ex.mr));
    chk("ex_memwrite", 32'(bus.ex_memwrite), 32'(m_ex.mw));
    chk("stall_id", 32'(bus.stall_id), 32'(load_use() && !bus.stall_ext));
  endtask

  task automatic model_edge();
    if (bus.stall_ext) begin
      if (bus.flush) m_pend = 1;
    end else if (bus.flush || m_pend) begin
      m_ex = bubble(); m_pend = 0;
    end else if (load_use()) begin
      m_ex = bubble();
    end else begin
      m_ex = id_ins();
    end
  endtask

  // Check outputs mid-cycle, then advance DUT and model on the same edge
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_id(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc, input bit s1pc,
                          input bit s2imm, input logic [3:0] ctrl, input bit mr,
                          input bit mw, input bit rw);
    bus.id_valid = v; bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_rd = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_pc = pc;
    bus.id_src1_pc = s1pc; bus.id_src2_imm = s2imm; bus.id_aluctrl = ctrl;
    bus.id_memread = mr; bus.id_memwrite = mw; bus.id_regwrite = rw;
  endtask

  task automatic clr_fwd();
    bus.exmem_rd = 0; bus.exmem_regwrite = 0; bus.exmem_result = 0;
    bus.memwb_rd = 0; bus.memwb_regwrite = 0; bus.memwb_wdata = 0;
  endtask

  initial begin
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA};
    rst_n = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 0; bus.stall_ext = 0;
    clr_fwd();
    m_ex = bubble(); m_pend = 0;
    #3;
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
    chk("rst_aluctrl", 32'(bus.alu_aluctrl), 32'h0);
    chk("rst_src1", bus.alu_src1, 32'h0);
    chk("rst_stall_id", 32'(bus.stall_id), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); model_edge(); #1;

    // Back-to-back dependency: x3 comes from EX/MEM, not the stale regfile value
    drive_id(1, 1, 2, 3, 32'h10, 32'h20, 0, 32'h40, 0, 0, ALU_ADD, 0, 0, 1);
    step();
    drive_id(1, 3, 1, 4, 32'hAAAA, 32'h10, 0, 32'h44, 0, 0, ALU_ADD, 0, 0, 1);
    step();
    bus.exmem_rd = 3; bus.exmem_regwrite = 1; bus.exmem_result = 32'h55;
    #1;
    chk("t2_src1_fwd", bus.alu_src1, 32'h55);
    chk("t2_ex_rd", 32'(bus.ex_rd), 32'd4);

    // Both producers target x5: EX/MEM wins; x0 never forwards
    drive_id(1, 5, 0, 6, 32'h99, 32'hFFFF, 0, 32'h48, 0, 0, ALU_OR, 0, 0, 1);
    step();
    bus.exmem_rd = 5; bus.exmem_regwrite = 1; bus.exmem_result = 32'h11;
    bus.memwb_rd = 5; bus.memwb_regwrite = 1; bus.memwb_wdata = 32'h22;
    #1;
    chk("t3_priority", bus.alu_src1, 32'h11);
    bus.exmem_regwrite = 0;
    #1;
    chk("t3_memwb", bus.alu_src1, 32'h22);
    bus.memwb_rd = 0; bus.memwb_wdata = 32'hFFFF;
    #1;
    chk("t3_x0_src2", bus.alu_src2, 32'h0);
    chk("t3_x0_store", bus.ex_store_data, 32'h0);
    clr_fwd();

    // Load-use: LW x7 then ADD x8,x7,x2 -> one stall cycle, bubble, then forward from MEM/WB
    drive_id(1, 1, 0, 7, 32'h1000, 0, 32'h8, 32'h4C, 0, 1, ALU_ADD, 1, 0, 1);
    step();
    drive_id(1, 7, 2, 8, 32'hDEAD, 32'h3, 0, 32'h50, 0, 0, ALU_ADD, 0, 0, 1);
    #1;
    chk("t4_stall", 32'(bus.stall_id), 32'h1);
    step();
    chk("t4_bubble", 32'(bus.ex_valid), 32'h0);
    chk("t4_stall_drop", 32'(bus.stall_id), 32'h0);
    step();
    bus.memwb_rd = 7; bus.memwb_regwrite = 1; bus.memwb_wdata = 32'h77;
    #1;
    chk("t4_capture_rd", 32'(bus.ex_rd), 32'd8);
    chk("t4_fwd_memwb", bus.alu_src1, 32'h77);
    clr_fwd();

    // Flush during a 3-cycle external stall: EX holds, then a bubble replaces the stale ID op
    drive_id(1, 1, 2, 9, 32'h1, 32'h2, 0, 32'h54, 0, 0, ALU_SUB, 0, 0, 1);
    bus.flush = 1; bus.stall_ext = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_rd", 32'(bus.ex_rd), 32'd8);
      chk("t5_hold_valid", 32'(bus.ex_valid), 32'h1);
    end
    bus.flush = 0; bus.stall_ext = 0;
    step();
    chk("t5_bubble_valid", 32'(bus.ex_valid), 32'h0);
    chk("t5_bubble_rd", 32'(bus.ex_rd), 32'h0);

    // PC and immediate operands; store data still carries forwarded rs2
    drive_id(1, 1, 2, 10, 32'h5, 32'h1234, 32'hFFFFFFFC, 32'h100, 1, 1, ALU_ADD, 0, 1, 0);
    step();
    chk("t6_src1_pc", bus.alu_src1, 32'h100);
    chk("t6_src2_imm", bus.alu_src2, 32'hFFFFFFFC);
    chk("t6_store", bus.ex_store_data, 32'h1234);
    bus.exmem_rd = 2; bus.exmem_regwrite = 1; bus.exmem_result = 32'hBEEF;
    #1;
    chk("t6_store_fwd", bus.ex_store_data, 32'hBEEF);
    chk("t6_src2_keep", bus.alu_src2, 32'hFFFFFFFC);
    clr_fwd();

    // Random traffic with small register indices to provoke forwarding and hazards
    for (int n = 0; n < 400; n++) begin
      drive_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               ops[$urandom_range(0, 8)], $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.stall_ext = ($urandom_range(0, 5) == 0);
      bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_regwrite = $urandom_range(0, 1) == 1;
      bus.exmem_result = $urandom;
      bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_regwrite = $urandom_range(0, 1) == 1;
      bus.memwb_wdata = $urandom;
      step();
    end

    // Mid-stream reset with a pending flush: reset clears EX and discards the flush
    clr_fwd();
    bus.flush = 0; bus.stall_ext = 0;
    drive_id(1, 1, 2, 12, 32'h1, 32'h2, 0, 32'h200, 0, 0, ALU_ADD, 0, 0, 1);
    step();
    bus.flush = 1; bus.stall_ext = 1;
    step();
    bus.flush = 0; bus.stall_ext = 0;
    drive_id(1, 3, 4, 11, 32'h3, 32'h4, 0, 32'h204, 0, 0, ALU_XOR, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    chk("t1_rst_valid", 32'(bus.ex_valid), 32'h0);
    chk("t1_rst_aluctrl", 32'(bus.alu_aluctrl), 32'h0);
    chk("t1_rst_stall", 32'(bus.stall_id), 32'h0);
    m_ex = bubble(); m_pend = 0;
    #1;
    rst_n = 1'b1;
    step();
    chk("t1_no_stale_flush", 32'(bus.ex_valid), 32'h1);
    chk("t1_capture_rd", 32'(bus.ex_rd), 32'd11);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
